// File: rtl/elevator_pkg.sv
// Shared types and floor-vector helpers for the SCAN elevator controller.
// Floor vectors are widened to MAX_FLOORS so the helpers work for any car size.
package elevator_pkg;
  localparam int MAX_FLOORS = 16;

  typedef enum logic [2:0] {
    ST_IDLE, ST_MOVE_UP, ST_MOVE_DOWN, ST_DOOR, ST_ESTOP, ST_FAULT
  } elev_state_t;

  typedef logic [MAX_FLOORS-1:0] floor_vec_t;

  function automatic logic onehot_ok(input floor_vec_t v);
    return (v != '0) && ((v & (v - floor_vec_t'(1))) == '0);
  endfunction

  function automatic logic [3:0] onehot_idx(input floor_vec_t v);
    logic [3:0] idx;
    idx = '0;
    for (int i = 0; i < MAX_FLOORS; i++)
      if (v[i]) idx = 4'(i);
    return idx;
  endfunction

  function automatic logic req_above(input floor_vec_t p, input logic [3:0] f, input int floors);
    logic r;
    r = 1'b0;
    for (int i = 0; i < MAX_FLOORS; i++)
      if (p[i] && i > int'(f) && i < floors) r = 1'b1;
    return r;
  endfunction

  function automatic logic req_below(input floor_vec_t p, input logic [3:0] f, input int floors);
    logic r;
    r = 1'b0;
    for (int i = 0; i < MAX_FLOORS; i++)
      if (p[i] && i < int'(f) && i < floors) r = 1'b1;
    return r;
  endfunction
endpackage

// File: rtl/elevator_scan_ctrl_door_timer.sv
// Loadable down-counter; load/hold both restart the count, expired marks the last cycle.
module door_timer #(
  parameter int unsigned MAX = 8
) (
  input  logic clock,
  input  logic reset,
  input  logic load,
  input  logic hold,
  output logic expired
);
  localparam int W = $clog2(MAX + 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clock or negedge reset)
    if (!reset)             cnt <= '0;
    else if (load || hold)  cnt <= W'(MAX);
    else if (cnt != '0)     cnt <= cnt - W'(1);

  // load is deliberately not part of expired: it would close a loop through the FSM.
  assign expired = !hold && (cnt <= W'(1));
endmodule

// File: rtl/elevator_scan_ctrl.sv
// N-floor SCAN elevator controller: latched calls, timed door, stall fault, emergency stop.
module elevator_scan_ctrl import elevator_pkg::*; #(
  parameter  int FLOORS       = 4,
  parameter  int DOOR_CYCLES  = 100_000_000,
  parameter  int MOVE_TIMEOUT = 500_000_000,
  localparam int FW           = $clog2(FLOORS)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [FLOORS-1:0] call_req,
  input  logic [FLOORS-1:0] floor_sensor,
  input  logic              door_hold,
  input  logic              estop,
  output logic              motor_up,
  output logic              motor_down,
  output logic              door_open,
  output logic [FW-1:0]     cur_floor,
  output logic              dir_up,
  output logic [FLOORS-1:0] pending,
  output logic              fault
);
  localparam logic [3:0] TOP_IDX = 4'(FLOORS - 1);

  elev_state_t       state, next_state;
  floor_vec_t        sens_w, pend_w, pend_eff_w, call_w;
  logic              sens_ok, sens_multi, new_hit, at_floor, moving, call_here;
  logic              door_exp, stall_exp, up_req, down_req;
  logic [3:0]        sens_idx, cur_idx;
  logic [FW-1:0]     pos_next;
  logic              motor_up_d, motor_down_d, door_open_d, fault_d, dir_up_d;
  logic [FLOORS-1:0] pending_d;

  assign sens_w     = floor_vec_t'(floor_sensor);
  assign pend_w     = floor_vec_t'(pending);
  assign pend_eff_w = floor_vec_t'(pending | call_req);
  assign call_w     = floor_vec_t'(call_req);
  assign sens_ok    = onehot_ok(sens_w);
  assign sens_multi = (sens_w != '0) && !sens_ok;
  assign sens_idx   = onehot_idx(sens_w);
  assign cur_idx    = 4'(cur_floor);
  assign pos_next   = sens_ok ? FW'(sens_idx) : cur_floor;
  assign at_floor   = sens_ok && (sens_idx == cur_idx);
  assign new_hit    = sens_ok && (sens_idx != cur_idx);
  assign moving     = (state == ST_MOVE_UP) || (state == ST_MOVE_DOWN);
  assign call_here  = call_w[cur_idx];
  assign up_req     = req_above(pend_w, cur_idx, FLOORS);
  assign down_req   = req_below(pend_w, cur_idx, FLOORS);

  door_timer #(.MAX(DOOR_CYCLES)) u_door (
    .clock   (clock),
    .reset   (reset),
    .load    ((next_state == ST_DOOR) && (state != ST_DOOR)),
    .hold    ((state == ST_DOOR) && (door_hold || call_here)),
    .expired (door_exp)
  );

  // Stall watchdog is kept full whenever the car is not moving or reaches a new floor.
  door_timer #(.MAX(MOVE_TIMEOUT)) u_stall (
    .clock   (clock),
    .reset   (reset),
    .load    (1'b0),
    .hold    (!moving || new_hit),
    .expired (stall_exp)
  );

  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      state      <= ST_IDLE;
      cur_floor  <= '0;
      dir_up     <= 1'b1;
      pending    <= '0;
      motor_up   <= 1'b0;
      motor_down <= 1'b0;
      door_open  <= 1'b0;
      fault      <= 1'b0;
    end else begin
      state      <= next_state;
      cur_floor  <= pos_next;
      dir_up     <= dir_up_d;
      pending    <= pending_d;
      motor_up   <= motor_up_d;
      motor_down <= motor_down_d;
      door_open  <= door_open_d;
      fault      <= fault_d;
    end

  always_comb begin
    next_state = state;
    if (state == ST_FAULT)  next_state = ST_FAULT;
    else if (estop)         next_state = ST_ESTOP;
    else if (sens_multi)    next_state = ST_FAULT;
    else begin
      case (state)
        ST_IDLE:
          if (pend_w[cur_idx] && at_floor)      next_state = ST_DOOR;
          else if (up_req && (dir_up || !down_req)) next_state = ST_MOVE_UP;
          else if (down_req)                    next_state = ST_MOVE_DOWN;
        ST_MOVE_UP, ST_MOVE_DOWN:
          if (stall_exp)                        next_state = ST_FAULT;
          else if (sens_ok && pend_eff_w[sens_idx]) next_state = ST_DOOR;
          else if (sens_ok && state == ST_MOVE_UP && sens_idx == TOP_IDX) next_state = ST_IDLE;
          else if (sens_ok && state == ST_MOVE_DOWN && sens_idx == 4'd0)  next_state = ST_IDLE;
        ST_DOOR:
          if (door_exp) next_state = ST_IDLE;
        ST_ESTOP:
          next_state = ST_IDLE;
        default:
          next_state = state;
      endcase
    end
  end

  always_comb begin
    motor_up_d   = (next_state == ST_MOVE_UP);
    motor_down_d = (next_state == ST_MOVE_DOWN);
    door_open_d  = (next_state == ST_DOOR) || ((next_state == ST_ESTOP) && door_open);
    fault_d      = (next_state == ST_FAULT);
    dir_up_d     = dir_up;
    if (next_state == ST_MOVE_UP)   dir_up_d = 1'b1;
    if (next_state == ST_MOVE_DOWN) dir_up_d = 1'b0;
    // A call for the floor the door is open at is served, never latched.
    pending_d = pending | call_req;
    if (next_state == ST_DOOR) pending_d[pos_next] = 1'b0;
  end
endmodule

// File: tb/tb_elevator_scan_ctrl.sv
// Directed bench for elevator_scan_ctrl with FLOORS=4, DOOR_CYCLES=8, MOVE_TIMEOUT=50.
module tb_elevator_scan_ctrl;
  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] call_req = '0;
  logic [3:0] floor_sensor = 4'b0001;
  logic       door_hold = 1'b0;
  logic       estop = 1'b0;
  logic       motor_up, motor_down, door_open, dir_up, fault;
  logic [1:0] cur_floor;
  logic [3:0] pending;

  int checks = 0;
  int errors = 0;
  int n;

  always #5 clock = ~clock;

  elevator_scan_ctrl #(.FLOORS(4), .DOOR_CYCLES(8), .MOVE_TIMEOUT(50)) dut (
    .clock        (clock),
    .reset        (reset),
    .call_req     (call_req),
    .floor_sensor (floor_sensor),
    .door_hold    (door_hold),
    .estop        (estop),
    .motor_up     (motor_up),
    .motor_down   (motor_down),
    .door_open    (door_open),
    .cur_floor    (cur_floor),
    .dir_up       (dir_up),
    .pending      (pending),
    .fault        (fault)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic call(input logic [3:0] c);
    call_req = c;
    step();
    call_req = '0;
  endtask

  // Car leaves the current floor, travels two cycles, then hits floor f.
  task automatic pass_floor(input int f);
    floor_sensor = '0;
    step();
    step();
    floor_sensor = 4'(1 << f);
    step();
  endtask

  task automatic door_len(output int len);
    len = 0;
    while (door_open && len < 200) begin
      len++;
      step();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    repeat (2) step();
    chk("rst_motor_up", motor_up, 0);
    chk("rst_motor_down", motor_down, 0);
    chk("rst_door", door_open, 0);
    chk("rst_fault", fault, 0);
    chk("rst_pending", pending, 0);
    chk("rst_floor", cur_floor, 0);
    chk("rst_dir", dir_up, 1);
    reset = 1'b1;
    step();

    // floor 0 -> 3 with no intermediate stops
    call(4'b1000);
    chk("t1_pend", pending, 4'b1000);
    chk("t1_motor_early", motor_up, 0);
    step();
    chk("t1_motor_up", motor_up, 1);
    pass_floor(1);
    chk("t1_floor1", cur_floor, 1);
    chk("t1_pass1", motor_up, 1);
    pass_floor(2);
    chk("t1_pass2", motor_up, 1);
    pass_floor(3);
    chk("t1_arr_motor", motor_up, 0);
    chk("t1_arr_door", door_open, 1);
    chk("t1_arr_pend", pending, 0);
    chk("t1_arr_floor", cur_floor, 3);
    door_len(n);
    chk("t1_door_len", n, 8);

    // down to 0, then SCAN from floor 1 going up with calls at 3 and 0
    call(4'b0001);
    step();
    chk("t2_down", motor_down, 1);
    chk("t2_dir_dn", dir_up, 0);
    pass_floor(2);
    pass_floor(1);
    pass_floor(0);
    chk("t2_arr0", door_open, 1);
    door_len(n);
    call(4'b0010);
    step();
    chk("t2_up1", motor_up, 1);
    chk("t2_dir_up", dir_up, 1);
    floor_sensor = '0;
    call(4'b1001);
    chk("t2_pend3", pending, 4'b1011);
    pass_floor(1);
    chk("t2_stop1", door_open, 1);
    chk("t2_pend_after1", pending, 4'b1001);
    door_len(n);
    chk("t2_gap", {motor_up, motor_down}, 0);
    step();
    chk("t2_scan_up", motor_up, 1);
    chk("t2_scan_dir", dir_up, 1);
    pass_floor(2);
    chk("t2_skip2", motor_up, 1);
    pass_floor(3);
    chk("t2_stop3", door_open, 1);
    chk("t2_pend_after3", pending, 4'b0001);
    door_len(n);
    chk("t2_rev_gap", {motor_up, motor_down}, 0);
    step();
    chk("t2_rev_down", motor_down, 1);
    chk("t2_rev_dir", dir_up, 0);
    pass_floor(2);
    pass_floor(1);
    chk("t2_skip1", motor_down, 1);
    pass_floor(0);
    chk("t2_stop0", door_open, 1);
    chk("t2_pend_empty", pending, 0);
    door_len(n);

    // door hold and same-floor call reload
    call(4'b0001);
    step();
    chk("t3_open", door_open, 1);
    chk("t3_pend", pending, 0);
    door_hold = 1'b1;
    repeat (20) step();
    door_hold = 1'b0;
    chk("t3_held", door_open, 1);
    repeat (3) step();
    call(4'b0001);
    chk("t3_call_pend", pending, 0);
    door_len(n);
    chk("t3_reload_len", n, 8);

    // emergency stop mid-move
    call(4'b0100);
    step();
    chk("t4_move", motor_up, 1);
    floor_sensor = '0;
    step();
    estop = 1'b1;
    step();
    chk("t4_stop_up", motor_up, 0);
    chk("t4_stop_dn", motor_down, 0);
    chk("t4_pend_kept", pending, 4'b0100);
    call(4'b0001);
    chk("t4_pend_latch", pending, 4'b0101);
    estop = 1'b0;
    step();
    chk("t4_idle", motor_up, 0);
    step();
    chk("t4_resume", motor_up, 1);
    pass_floor(1);
    chk("t4_skip1", motor_up, 1);
    pass_floor(2);
    chk("t4_stop2", door_open, 1);
    chk("t4_pend", pending, 4'b0001);
    door_len(n);
    step();
    chk("t4_down", motor_down, 1);
    pass_floor(1);
    pass_floor(0);
    chk("t4_stop0", door_open, 1);
    door_len(n);

    // motor stall
    call(4'b1000);
    step();
    chk("t5_move", motor_up, 1);
    floor_sensor = '0;
    n = 0;
    while (motor_up && n < 200) begin
      n++;
      step();
    end
    chk("t5_stall_len", n, 50);
    chk("t5_fault", fault, 1);
    chk("t5_motor_dn", motor_down, 0);
    chk("t5_door", door_open, 0);
    estop = 1'b1;
    repeat (3) step();
    estop = 1'b0;
    step();
    chk("t5_sticky", fault, 1);
    chk("t5_sticky_motor", motor_up, 0);
    floor_sensor = 4'b0001;
    reset = 1'b0;
    #1;
    chk("t5_reset_clr", fault, 0);
    step();
    reset = 1'b1;
    step();

    // reset mid-move
    call(4'b1000);
    step();
    chk("t6_move", motor_up, 1);
    floor_sensor = '0;
    step();
    #2 reset = 1'b0;
    #1;
    chk("t6_async_motor", motor_up, 0);
    chk("t6_pend_lost", pending, 0);
    floor_sensor = 4'b0001;
    step();
    reset = 1'b1;
    repeat (2) step();
    chk("t6_stays_idle", motor_up, 0);

    // multiple sensors active
    floor_sensor = 4'b0110;
    step();
    chk("t7_multi_fault", fault, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
